// File: rtl/fsm_lab_pkg.sv
// Definitions shared by the lab-3 counter top and its receive-side checker.
// Holds the checker state encoding and the default counter width.
package fsm_lab_pkg;

  localparam int COUNT_W = 13;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones and clears synchronously on clr.
// clr has priority over inc.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/fsm_count_checker.sv
// Receive-side checker for the lab-3 counter stream: locks onto a run of
// +1 increments, flags restarts and sequence errors, and counts errors.
module fsm_count_checker
  import fsm_lab_pkg::*;
#(
  parameter int WIDTH  = COUNT_W,
  parameter int LOCK_N = 4,
  parameter int ERRW   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic             restart_pulse,
  output logic [ERRW-1:0]  err_count,
  output logic [WIDTH-1:0] expected
);

  localparam int GW = $clog2(LOCK_N + 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] prev_reg, prev_next;
  logic [GW-1:0]    good_reg, good_next;
  logic             err_reg, err_next;
  logic             restart_reg, restart_next;

  logic [WIDTH-1:0] expected_w;
  logic [GW-1:0]    good_inc;
  logic             match;

  // Wrap from all-ones to zero falls out of the WIDTH-bit add and counts as a match.
  assign expected_w = prev_reg + WIDTH'(1);
  assign match      = (in_data == expected_w);
  assign good_inc   = good_reg + GW'(1);

  always_comb begin
    state_next   = state_reg;
    prev_next    = prev_reg;
    good_next    = good_reg;
    err_next     = 1'b0;
    restart_next = 1'b0;
    if (in_valid) begin
      prev_next = in_data;
      case (state_reg)
        ST_HUNT: begin
          good_next  = '0;
          state_next = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (match) begin
            good_next = good_inc;
            if (good_inc == GW'(LOCK_N)) begin
              state_next = ST_LOCKED;
            end
          end else begin
            good_next = '0;
          end
        end
        ST_LOCKED: begin
          if (!match) begin
            if (in_data == '0) begin
              restart_next = 1'b1;
            end else begin
              err_next   = 1'b1;
              good_next  = '0;
              state_next = ST_ACQUIRE;
            end
          end
        end
        default: begin
          good_next  = '0;
          state_next = ST_HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_HUNT;
      prev_reg    <= '0;
      good_reg    <= '0;
      err_reg     <= 1'b0;
      restart_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      prev_reg    <= prev_next;
      good_reg    <= good_next;
      err_reg     <= err_next;
      restart_reg <= restart_next;
    end
  end

  // Counts on the same edge that raises err_pulse, so both move together.
  sat_counter #(
    .W (ERRW)
  ) u_err_count (
    .clk   (clk),
    .clr   (reset),
    .inc   (err_next),
    .count (err_count)
  );

  assign locked        = (state_reg == ST_LOCKED);
  assign err_pulse     = err_reg;
  assign restart_pulse = restart_reg;
  assign expected      = expected_w;

endmodule
